// File: rtl/bit_stream_serializer_if.sv
// Word-input handshake for the bit stream serializer.
// A word transfers on a rising clk edge where in_valid && in_ready are both high;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface bit_stream_serializer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_stream_serializer.sv
// Queues parallel words in a small FIFO and shifts them out one bit at a time,
// back-to-back words forming a gapless stream; IDLE_BIT is driven between words.
module bit_stream_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  bit_stream_serializer_if.slave        in_bus,
  output logic                          dout_bit,
  output logic                          bit_valid,
  output logic                          word_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   sh_q, sh_d, sh_next, head;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                dout_q, dout_d;
  logic                push, pop, div_last, bit_last;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign in_bus.in_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push     = in_bus.in_valid && in_bus.in_ready;
  assign head     = mem[rd_ptr_q];
  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(DATA_W - 1));
  assign sh_next  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    dout_d    = dout_q;
    pop       = 1'b0;
    bit_valid = 1'b0;
    word_done = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = IDLE_BIT;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SHIFT;
          sh_d    = head;
          bit_d   = '0;
          div_d   = '0;
          dout_d  = first_bit(head);
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        bit_valid = (div_q == '0);
        if (!div_last) begin
          div_d = div_q + DIV_W'(1);
        end else if (!bit_last) begin
          div_d  = '0;
          bit_d  = bit_q + BIT_W'(1);
          sh_d   = sh_next;
          dout_d = first_bit(sh_next);
        end else begin
          word_done = 1'b1;
          // Chain straight into the next queued word so the stream has no gap.
          if (count_q != '0) begin
            pop    = 1'b1;
            sh_d   = head;
            bit_d  = '0;
            div_d  = '0;
            dout_d = first_bit(head);
          end else begin
            state_d = IDLE;
            dout_d  = IDLE_BIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sh_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      dout_q   <= IDLE_BIT;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      dout_q  <= dout_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_bus.in_data;
  end

  assign dout_bit   = dout_q;
  assign fifo_count = count_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Three serializer lanes (defaults, CLK_DIV=3, LSB-first) checked against a
// word-level model: accepted words expand into expected bits in a queue.
module tb_bit_stream_serializer;
  typedef struct packed {logic b; logic first; logic last;} ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data_a [3];
  logic       in_valid_a [3];
  logic [2:0] dout_v, bv_v, wd_v, busy_v, ready_v, st_v;
  logic [8:0] cnt_v;
  int         checks = 0;
  int         failures = 0;
  int         stalls = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d t=%0t actual=%0h expected=%0h", name, ln, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CD = (g == 1) ? 3 : 1;
    localparam bit MF = (g == 2) ? 1'b0 : 1'b1;

    bit_stream_serializer_if #(.DATA_W(8)) bus ();
    assign bus.in_data  = in_data_a[g];
    assign bus.in_valid = in_valid_a[g];
    assign ready_v[g]   = bus.in_ready;

    bit_stream_serializer #(
      .DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(CD), .MSB_FIRST(MF), .IDLE_BIT(1'b1)
    ) dut (
      .clk(clk), .rst(rst), .in_bus(bus),
      .dout_bit(dout_v[g]), .bit_valid(bv_v[g]), .word_done(wd_v[g]),
      .busy(busy_v[g]), .fifo_count(cnt_v[3*g +: 3]), .state_dbg(st_v[g])
    );

    ent_t exp_q [$];
    int   acc = 0, started = 0, phase = 0, pend;
    logic cur_bit = 1'b1, cur_last = 1'b0, exp_bv = 1'b0, exp_busy = 1'b0, have_exp = 1'b0;

    // Expected bits are queued the moment a word is accepted.
    always @(posedge clk) begin
      if (!rst && bus.in_valid && bus.in_ready) begin
        acc++;
        for (int i = 0; i < 8; i++) begin
          ent_t e;
          e.b     = MF ? bus.in_data[7-i] : bus.in_data[i];
          e.first = (i == 0);
          e.last  = (i == 7);
          exp_q.push_back(e);
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        acc = 0; started = 0; phase = 0; have_exp = 1'b0;
      end else begin
        if (have_exp) begin
          chk("bit_valid", g, 32'(bv_v[g]), 32'(exp_bv));
          chk("busy", g, 32'(busy_v[g]), 32'(exp_busy));
        end
        if (bv_v[g]) begin
          if (exp_q.size() == 0) chk("spurious_bit", g, 32'd1, 32'd0);
          else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("dout_bit", g, 32'(dout_v[g]), 32'(e.b));
            cur_bit = e.b; cur_last = e.last;
            if (e.first) started++;
          end
          phase = 0;
        end else if (busy_v[g]) begin
          phase++;
          chk("dout_hold", g, 32'(dout_v[g]), 32'(cur_bit));
        end else begin
          chk("dout_idle", g, 32'(dout_v[g]), 32'd1);
        end
        chk("word_done", g, 32'(wd_v[g]), 32'(busy_v[g] && cur_last && phase == CD - 1));
        pend = acc - started;
        chk("fifo_count", g, 32'(cnt_v[3*g +: 3]), 32'(pend));
        chk("in_ready", g, 32'(ready_v[g]), 32'(pend < 4));
        // Next strobe: end of a bit period with more bits to go, or a word waiting.
        exp_bv   = busy_v[g] ? (phase == CD - 1 && (!cur_last || pend > 0)) : (pend > 0);
        exp_busy = exp_bv || (busy_v[g] && !(phase == CD - 1 && cur_last));
        have_exp = 1'b1;
      end
    end
  end

  // Caller sits just after a negedge; in_ready is stable until the next posedge.
  task automatic push(input int k, input logic [7:0] w);
    logic r, done;
    done = 1'b0;
    in_data_a[k]  = w;
    in_valid_a[k] = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      r = ready_v[k];
      if (!r) stalls++;
      @(negedge clk);
      if (r) done = 1'b1;
    end
    in_valid_a[k] = 1'b0;
    if (!done) chk("push_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int k);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!busy_v[k] && cnt_v[3*k +: 3] == 3'd0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", k, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_data_a[k]  = '0;
      in_valid_a[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_dout", k, 32'(dout_v[k]), 32'd1);
      chk("rst_bit_valid", k, 32'(bv_v[k]), 32'd0);
      chk("rst_word_done", k, 32'(wd_v[k]), 32'd0);
      chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
      chk("rst_count", k, 32'(cnt_v[3*k +: 3]), 32'd0);
      chk("rst_ready", k, 32'(ready_v[k]), 32'd1);
    end
    #1 rst = 1'b0;

    // Single words on each lane, then back-to-back pair.
    push(0, 8'h5A); wait_idle(0);
    push(1, 8'h0F); wait_idle(1);
    push(2, 8'h01); wait_idle(2);
    push(0, 8'h5A); push(0, 8'hA5); wait_idle(0);

    // Six words with in_valid held: FIFO fills and the last word stalls.
    stalls = 0;
    for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i));
    chk("full_stall", 0, 32'(stalls > 0), 32'd1);
    wait_idle(0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(k, 8'($urandom));
      end
      wait_idle(k);
    end

    // Reset during the 4th bit of a word with two words queued.
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout", 0, 32'(dout_v[0]), 32'd1);
    chk("midrst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("midrst_count", 0, 32'(cnt_v[2:0]), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("post_rst_count", 0, 32'(cnt_v[2:0]), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
